// File: rtl/shf_iter_unit.sv
// rtl/shf_iter_unit.sv - iterative shift/rotate/swap unit, one position per clock
module shf_iter_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       s,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] y,
    output logic             done,
    output logic             busy
);

    localparam int H = WIDTH / 2;
    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opr;
    logic [2:0]       mode;
    logic [AMT_W-1:0] cnt;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic [2:0] m);
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            3'd1:    r = {1'b0, v[WIDTH-1:1]};
            3'd2:    r = {v[WIDTH-2:0], 1'b0};
            3'd3:    r = {v[0], v[WIDTH-1:1]};
            3'd4:    r = {v[WIDTH-2:0], v[WIDTH-1]};
            3'd5:    r = {v[WIDTH-1], v[WIDTH-1:1]};
            3'd6:    r = {v[H-1:0], v[WIDTH-1:H]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // y is only written when the count is exhausted, so intermediate steps stay hidden
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opr  <= '0;
            mode <= '0;
            cnt  <= '0;
            y    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opr  <= d;
                        mode <= s;
                        cnt  <= amt;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        opr <= step(opr, mode);
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        y <= opr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;
    assign done     = (state == DONE);

endmodule

// File: tb/tb_shf_iter_unit.sv
// tb/tb_shf_iter_unit.sv - self-checking bench for shf_iter_unit
module tb_shf_iter_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_ready;
    logic [7:0] d;
    logic [2:0] s;
    logic [2:0] amt;
    logic [7:0] y;
    logic       done;
    logic       busy;

    int total = 0;
    int bad   = 0;

    shf_iter_unit #(.WIDTH(8), .AMT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_ready (in_ready),
        .d        (d),
        .s        (s),
        .amt      (amt),
        .y        (y),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic [2:0] amt;
        logic [7:0] y;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one request and follows it to completion; hammer keeps start high with junk while busy
    task automatic run_op(input string tag, input logic [7:0] vd, input logic [2:0] vs,
                          input logic [2:0] va, input logic [7:0] expy, input bit hammer);
        int n;
        logic [7:0] yprev;
        bit y_moved;
        bit rdy_seen;
        @(negedge clk);
        chk({tag, " ready_before"}, in_ready, 1'b1);
        yprev = y;
        start = 1'b1;
        d = vd;
        s = vs;
        amt = va;
        @(negedge clk);
        start = hammer;
        d = ~vd;
        s = 3'($urandom);
        amt = 3'($urandom);
        n = 0;
        y_moved = 0;
        rdy_seen = 0;
        while (!done && n < 40) begin
            if (y !== yprev) y_moved = 1;
            if (in_ready !== 1'b0 || busy !== 1'b1) rdy_seen = 1;
            @(negedge clk);
            if (hammer) begin
                d = 8'($urandom);
                s = 3'($urandom);
                amt = 3'($urandom);
            end
            n++;
        end
        start = 1'b0;
        chk({tag, " latency"}, n, va + 1);
        chk({tag, " y"}, y, expy);
        chk({tag, " y_hidden"}, y_moved, 1'b0);
        chk({tag, " busy_while_op"}, rdy_seen, 1'b0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, done, 1'b0);
        chk({tag, " ready_after"}, {in_ready, busy}, 2'b10);
        chk({tag, " y_hold"}, y, expy);
    endtask

    initial begin
        vecs[0]  = '{8'h96, 3'd1, 3'd3, 8'h12};
        vecs[1]  = '{8'h96, 3'd5, 3'd2, 8'hE5};
        vecs[2]  = '{8'h96, 3'd2, 3'd7, 8'h00};
        vecs[3]  = '{8'h96, 3'd4, 3'd3, 8'hB4};
        vecs[4]  = '{8'h96, 3'd3, 3'd0, 8'h96};
        vecs[5]  = '{8'h96, 3'd6, 3'd1, 8'h69};
        vecs[6]  = '{8'h96, 3'd6, 3'd2, 8'h96};
        vecs[7]  = '{8'h5A, 3'd7, 3'd5, 8'h5A};
        vecs[8]  = '{8'h3C, 3'd0, 3'd4, 8'h3C};
        vecs[9]  = '{8'h96, 3'd3, 3'd1, 8'h4B};
        vecs[10] = '{8'h96, 3'd3, 3'd3, 8'hD2};
        vecs[11] = '{8'h96, 3'd5, 3'd7, 8'hFF};
        vecs[12] = '{8'h76, 3'd5, 3'd2, 8'h1D};
        vecs[13] = '{8'h80, 3'd1, 3'd7, 8'h01};
        vecs[14] = '{8'h96, 3'd4, 3'd7, 8'h4B};
        vecs[15] = '{8'h01, 3'd2, 3'd7, 8'h80};

        rst_n = 1'b0;
        start = 1'b0;
        d = '0;
        s = '0;
        amt = '0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {y, done, in_ready, busy}, {8'h00, 1'b0, 1'b1, 1'b0});
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].s, vecs[i].amt, vecs[i].y, 1'b0);
        end

        // Requests fired every cycle while busy must all be dropped
        run_op("hammer", 8'h96, 3'd1, 3'd3, 8'h12, 1'b1);
        run_op("after_hammer", 8'h5A, 3'd6, 3'd1, 8'hA5, 1'b0);

        // Asynchronous abort mid-operation
        @(negedge clk);
        start = 1'b1;
        d = 8'h96;
        s = 3'd1;
        amt = 3'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort y", y, 8'hA5);
        chk("pre_abort busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort outputs", {y, done, in_ready, busy}, {8'h00, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        chk("abort held", {y, done, in_ready}, {8'h00, 1'b0, 1'b1});
        rst_n = 1'b1;
        run_op("post_reset", 8'hF0, 3'd1, 3'd4, 8'h0F, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
